disp_scan_ctrl: RTL

//  Time-multiplexed scan controller for the 4-digit 7-segment display. Holds four hex digits + DPs,

---
 rtl/disp_pkg.sv | 18 +
 rtl/seg7_decode.sv | 11 +
 rtl/disp_scan_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the 7-segment scan controller
package disp_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_t;

  localparam logic [11:0] DISP_OFF = 12'hFFF;

  // Active-low {dp,g,f,e,d,c,b,a} codes, hex 0 in the low byte.
  localparam logic [127:0] SEG_CODES = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - hex digit to active-low {g,f,e,d,c,b,a} segments
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_CODES[{hex, 3'b000} +: 7];

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit 7-segment scan controller with staged, frame-aligned updates
// Optional leading-zero blanking on digits 3..1 when DISP_LZB_EN is defined.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_TICKS = 100000,
  parameter int GAP_TICKS  = 100
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic        wr_dp,
  input  logic        commit,
  output logic [11:0] DISP,
  output logic        frame_tick,
  output logic        commit_pending
);

  localparam int MAX_TICKS = (SCAN_TICKS > GAP_TICKS) ? SCAN_TICKS : GAP_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] SCAN_LOAD = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  scan_state_t   state;
  logic [1:0]    digit;
  logic [CW-1:0] cnt;

  logic [3:0] stg_val   [4];
  logic [3:0] shown_val [4];
  logic [3:0] stg_dp;
  logic [3:0] shown_dp;

  logic [3:0] cur_val;
  logic [6:0] seg_dec;
  logic [6:0] seg_out;
  logic       last_step;
  logic       frame_end;
  logic       apply;
  logic       blank;

  assign cur_val = shown_val[digit];

  seg7_decode u_seg7_decode (
    .hex (cur_val),
    .seg (seg_dec)
  );

  // Frame ends on the final tick of digit 3's trailing state (GAP, or SHOW when there is no gap).
  assign last_step = (GAP_TICKS > 0) ? (state == ST_GAP) : (state == ST_SHOW);
  assign frame_end = enable && last_step && (digit == 2'd3) && (cnt == '0);
  assign apply     = frame_end || (state == ST_OFF);

`ifdef DISP_LZB_EN
  always_comb begin
    blank = (digit != 2'd0);
    for (int j = 0; j < 4; j++) begin
      if ((j >= int'(digit)) && (shown_val[j] != 4'd0)) blank = 1'b0;
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign seg_out = blank ? 7'h7F : seg_dec;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state          <= ST_OFF;
      digit          <= 2'd0;
      cnt            <= '0;
      DISP           <= DISP_OFF;
      frame_tick     <= 1'b0;
      commit_pending <= 1'b0;
      stg_dp         <= 4'd0;
      shown_dp       <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        stg_val[i]   <= 4'd0;
        shown_val[i] <= 4'd0;
      end
    end else begin
      if (wr_en) begin
        stg_val[wr_addr] <= wr_data;
        stg_dp[wr_addr]  <= wr_dp;
      end

      // A commit landing on the apply cycle itself waits for the next one.
      if (apply && commit_pending) begin
        shown_val      <= stg_val;
        shown_dp       <= stg_dp;
        commit_pending <= commit;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end

      frame_tick <= frame_end;

      if (enable && (state == ST_SHOW))
        DISP <= {~(4'b0001 << digit), ~shown_dp[digit], seg_out};
      else
        DISP <= DISP_OFF;

      if (!enable) begin
        state <= ST_OFF;
        digit <= 2'd0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            state <= ST_SHOW;
            digit <= 2'd0;
            cnt   <= SCAN_LOAD;
          end
          ST_SHOW: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (GAP_TICKS > 0) begin
              state <= ST_GAP;
              cnt   <= GAP_LOAD;
            end else begin
              digit <= digit + 2'd1;
              cnt   <= SCAN_LOAD;
            end
          end
          ST_GAP: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              state <= ST_SHOW;
              digit <= digit + 2'd1;
              cnt   <= SCAN_LOAD;
            end
          end
          default: begin
            state <= ST_OFF;
            digit <= 2'd0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
